step_counter: RTL and testbench

//  Parametrised loadable up/down counter; advances by a per-cycle step of 0..2^STEP_W-1.

---
 rtl/step_counter.sv | 90 +++++++++
 tb/tb_step_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
//------------------------------------------------------------------------------
// Module      : step_counter
// Description : Loadable up/down counter advancing by a 0..2^STEP_W-1 step per
//               cycle, with wrap or saturate on overflow, an overflow pulse and
//               a sticky overflow flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_counter #(
    parameter int WIDTH    = 4,
    parameter int STEP_W   = 2,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [WIDTH-1:0]  init,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  cnt,
    output logic              co,
    output logic              zero,
    output logic              ovf,
    output logic              ovf_sticky
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ZERO     = '0;

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_ovf_sticky;

    logic [WIDTH-1:0] w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_carry;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_ovf_event;

    // Both directions are formed one bit wider so the top bit is carry/borrow.
    assign w_step_ext = WIDTH'(step);
    assign w_sum      = {1'b0, r_cnt} + {1'b0, w_step_ext};
    assign w_diff     = {1'b0, r_cnt} - {1'b0, w_step_ext};
    assign w_carry    = dir ? w_diff[WIDTH] : w_sum[WIDTH];
    assign w_result   = dir ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];

    // A load takes priority over counting, so it never signals an overflow.
    assign w_ovf_event = en & ~ld & w_carry;

    generate
        if (SATURATE != 0) begin : g_saturate
            logic [WIDTH-1:0] w_clamp;
            assign w_clamp    = dir ? c_ZERO : c_ALL_ONES;
            assign w_next_cnt = w_carry ? w_clamp : w_result;
        end else begin : g_wrap
            assign w_next_cnt = w_result;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= c_ZERO;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (ld) begin
                r_cnt <= init;
            end else if (en) begin
                r_cnt <= w_next_cnt;
            end
            r_ovf        <= w_ovf_event;
            // Setting wins over clearing in the same cycle.
            r_ovf_sticky <= w_ovf_event | (r_ovf_sticky & ~clr_ovf);
        end
    end

    assign cnt        = r_cnt;
    assign co         = (r_cnt == c_ALL_ONES);
    assign zero       = (r_cnt == c_ZERO);
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;

endmodule

`default_nettype wire

// File: tb/tb_step_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_step_counter
// Description : Self-checking bench for step_counter; wrap and saturate
//               instances share one stimulus stream and an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_counter;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;
    localparam int MAXV   = (1 << WIDTH) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ld = 1'b0;
    logic [WIDTH-1:0]  init = '0;
    logic              en = 1'b0;
    logic              dir = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic              clr_ovf = 1'b0;

    logic [WIDTH-1:0]  cnt_w, cnt_s;
    logic              co_w, co_s, zero_w, zero_s;
    logic              ovf_w, ovf_s, stk_w, stk_s;

    int compared   = 0;
    int mismatched = 0;
    bit armed      = 1'b0;

    always #5 clk = ~clk;

    step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .ld(ld), .init(init), .en(en), .dir(dir),
        .step(step), .clr_ovf(clr_ovf), .cnt(cnt_w), .co(co_w), .zero(zero_w),
        .ovf(ovf_w), .ovf_sticky(stk_w)
    );

    step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .ld(ld), .init(init), .en(en), .dir(dir),
        .step(step), .clr_ovf(clr_ovf), .cnt(cnt_s), .co(co_s), .zero(zero_s),
        .ovf(ovf_s), .ovf_sticky(stk_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: counts as plain integers; out-of-range results are overflows.
    int mw = 0, ms = 0;
    bit ow = 0, os = 0, sw = 0, ss = 0;

    function automatic int next_val(input int cur, input bit sat, output bit ev);
        int t;
        t  = dir ? cur - int'(step) : cur + int'(step);
        ev = (t < 0) || (t > MAXV);
        if (!ev) return t;
        if (sat) return dir ? 0 : MAXV;
        return (t + MAXV + 1) % (MAXV + 1);
    endfunction

    always @(posedge clk) begin
        bit e1, e2;
        int n1, n2;
        if (rst) begin
            mw <= 0; ms <= 0; ow <= 0; os <= 0; sw <= 0; ss <= 0;
        end else if (ld) begin
            mw <= int'(init); ms <= int'(init); ow <= 0; os <= 0;
            sw <= sw && !clr_ovf; ss <= ss && !clr_ovf;
        end else if (en) begin
            n1 = next_val(mw, 1'b0, e1);
            n2 = next_val(ms, 1'b1, e2);
            mw <= n1; ms <= n2; ow <= e1; os <= e2;
            sw <= e1 || (sw && !clr_ovf); ss <= e2 || (ss && !clr_ovf);
        end else begin
            ow <= 0; os <= 0;
            sw <= sw && !clr_ovf; ss <= ss && !clr_ovf;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("w_cnt",  32'(cnt_w),  32'(mw));
            chk("w_co",   32'(co_w),   32'(mw == MAXV));
            chk("w_zero", 32'(zero_w), 32'(mw == 0));
            chk("w_ovf",  32'(ovf_w),  32'(ow));
            chk("w_stk",  32'(stk_w),  32'(sw));
            chk("s_cnt",  32'(cnt_s),  32'(ms));
            chk("s_co",   32'(co_s),   32'(ms == MAXV));
            chk("s_zero", 32'(zero_s), 32'(ms == 0));
            chk("s_ovf",  32'(ovf_s),  32'(os));
            chk("s_stk",  32'(stk_s),  32'(ss));
        end
    end

    // Inputs currently on the pins are captured at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; ld = 0; en = 0; dir = 0; step = '0; clr_ovf = 0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        idle(); ld = 1; init = v; tick(); ld = 0;
    endtask

    task automatic count(input logic d, input logic [STEP_W-1:0] s);
        idle(); en = 1; dir = d; step = s; tick(); en = 0;
    endtask

    initial begin
        #2;
        rst = 1;
        tick();
        armed = 1;
        chk("rst_cnt", 32'(cnt_w), 32'h0);
        chk("rst_zero", 32'(zero_w), 32'h1);
        chk("rst_co", 32'(co_w), 32'h0);
        tick();

        // 1: count up to all-ones
        load(4'hD);
        chk("t1_ld", 32'(cnt_w), 32'hD);
        count(0, 2'd1);
        chk("t1_e", 32'(cnt_w), 32'hE);
        count(0, 2'd1);
        chk("t1_f", 32'(cnt_w), 32'hF);
        chk("t1_co", 32'(co_w), 32'h1);
        chk("t1_ovf", 32'(ovf_w), 32'h0);

        // 2: overflow from F by 3
        count(0, 2'd3);
        chk("t2_wcnt", 32'(cnt_w), 32'h2);
        chk("t2_scnt", 32'(cnt_s), 32'hF);
        chk("t2_ovf", 32'(ovf_w), 32'h1);
        chk("t2_stk", 32'(stk_w), 32'h1);
        idle(); tick();
        chk("t2_pulse", 32'(ovf_w), 32'h0);
        chk("t2_stk_hold", 32'(stk_w), 32'h1);

        // 3: saturation both ways
        load(4'hE);
        count(0, 2'd3);
        chk("t3_sup", 32'(cnt_s), 32'hF);
        chk("t3_wup", 32'(cnt_w), 32'h1);
        chk("t3_sovf", 32'(ovf_s), 32'h1);
        load(4'h1);
        count(1, 2'd2);
        chk("t3_sdn", 32'(cnt_s), 32'h0);
        chk("t3_szero", 32'(zero_s), 32'h1);
        chk("t3_sovf2", 32'(ovf_s), 32'h1);
        chk("t3_wdn", 32'(cnt_w), 32'hF);

        // 4: ld beats en; step 0 holds
        idle(); ld = 1; en = 1; init = 4'h5; step = 2'd2; tick();
        chk("t4_ld", 32'(cnt_w), 32'h5);
        chk("t4_ovf", 32'(ovf_w), 32'h0);
        count(0, 2'd0);
        chk("t4_hold", 32'(cnt_w), 32'h5);

        // exact landing is not overflow
        load(4'hC);
        count(0, 2'd3);
        chk("land_up", 32'(ovf_s), 32'h0);
        load(4'h2);
        count(1, 2'd2);
        chk("land_dn", 32'(ovf_w), 32'h0);

        // 5: clear vs set in same cycle
        idle(); clr_ovf = 1; tick();
        chk("t5_clr", 32'(stk_w), 32'h0);
        load(4'hF);
        idle(); en = 1; step = 2'd1; clr_ovf = 1; tick();
        chk("t5_setwins", 32'(stk_w), 32'h1);
        chk("t5_wcnt", 32'(cnt_w), 32'h0);
        idle(); clr_ovf = 1; tick();
        chk("t5_cleared", 32'(stk_w), 32'h0);

        // 6: synchronous reset mid-count
        load(4'h9);
        idle(); rst = 1; en = 1; step = 2'd1; ld = 1; init = 4'h3;
        #2;
        chk("t6_pre", 32'(cnt_w), 32'h9);
        tick();
        chk("t6_post", 32'(cnt_w), 32'h0);
        chk("t6_zero", 32'(zero_w), 32'h1);
        idle();

        // mixed traffic checked against the model every cycle
        for (int i = 0; i < 60; i++) begin
            ld      = ($urandom_range(0, 7) == 0);
            init    = WIDTH'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            dir     = 1'($urandom);
            step    = STEP_W'($urandom);
            clr_ovf = ($urandom_range(0, 4) == 0);
            rst     = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
